// File: rtl/video_sync_meas_if.sv
// Sync inputs and recovered frame-geometry outputs of the sync measurement block.
// Slave side is the measurement block; master side is the sync source / consumer.
interface video_sync_meas_if;
    logic       hsync_in;
    logic       vsync_in;
    logic [8:0] vline;
    logic [8:0] lines_per_frame;
    logic [3:0] vs_width;
    logic       frame_strobe;
    logic       locked;
    logic       mode_50;
    logic       mode_60;
    logic       hs_lost;

    modport slave (
        input  hsync_in, vsync_in,
        output vline, lines_per_frame, vs_width, frame_strobe,
               locked, mode_50, mode_60, hs_lost
    );

    modport master (
        output hsync_in, vsync_in,
        input  vline, lines_per_frame, vs_width, frame_strobe,
               locked, mode_50, mode_60, hs_lost
    );
endinterface

// File: rtl/video_sync_meas.sv
// Recovers lines/frame, vsync width, line index, lock and 50/60 Hz class from hsync/vsync.
// Latency: 2 clk from input sample to registered outputs; no backpressure, free-running.
module video_sync_meas #(
    parameter logic [11:0] HTO      = 12'd4095,
    parameter logic [8:0]  LINES_50 = 9'd320,
    parameter logic [8:0]  LINES_60 = 9'd262
) (
    input  logic              clk,
    input  logic              rst,
    video_sync_meas_if.slave  sync_if
);

    logic        hs_meta_q, hs_sync_q, hs_hist_q;
    logic        vs_meta_q, vs_sync_q, vs_hist_q;

    logic [8:0]  vline_q,      vline_d;
    logic [8:0]  lpf_q,        lpf_d;
    logic [3:0]  vs_width_q,   vs_width_d;
    logic [3:0]  width_cnt_q,  width_cnt_d;
    logic        strobe_q,     strobe_d;
    logic        locked_q,     locked_d;
    logic        mode_50_q,    mode_50_d;
    logic        mode_60_q,    mode_60_d;
    logic        hs_lost_q,    hs_lost_d;
    logic [11:0] gap_q,        gap_d;
    logic [8:0]  prev_m_q,     prev_m_d;
    logic        prev_valid_q, prev_valid_d;
    logic        seen_vs_q,    seen_vs_d;
    logic        ovf_q,        ovf_d;

    logic        hs_rise;
    logic        vs_rise;
    logic        vs_fall;
    logic        timeout;
    logic [8:0]  vline_inc;
    logic [8:0]  meas;

    assign hs_rise   = hs_sync_q & ~hs_hist_q;
    assign vs_rise   = vs_sync_q & ~vs_hist_q;
    assign vs_fall   = ~vs_sync_q & vs_hist_q;
    assign vline_inc = (vline_q == 9'd511) ? 9'd511 : vline_q + 9'd1;
    // A coincident hsync closes the old frame before vline restarts at 0.
    assign meas      = hs_rise ? vline_inc : vline_q;
    assign timeout   = ~hs_rise && (gap_q != HTO) && ((gap_q + 12'd1) == HTO);

    always_comb begin
        vline_d      = vline_q;
        lpf_d        = lpf_q;
        vs_width_d   = vs_width_q;
        width_cnt_d  = width_cnt_q;
        strobe_d     = 1'b0;
        locked_d     = locked_q;
        hs_lost_d    = hs_lost_q;
        gap_d        = gap_q;
        prev_m_d     = prev_m_q;
        prev_valid_d = prev_valid_q;
        seen_vs_d    = seen_vs_q;
        ovf_d        = ovf_q;

        if (hs_rise) begin
            gap_d     = 12'd0;
            hs_lost_d = 1'b0;
            vline_d   = vline_inc;
            if (vline_inc == 9'd511) begin
                ovf_d = 1'b1;
            end
        end else if (gap_q != HTO) begin
            gap_d = gap_q + 12'd1;
        end

        if (vs_rise) begin
            width_cnt_d = hs_rise ? 4'd1 : 4'd0;
        end else if (vs_sync_q && hs_rise && (width_cnt_q != 4'd15)) begin
            width_cnt_d = width_cnt_q + 4'd1;
        end

        if (vs_fall) begin
            vs_width_d = width_cnt_q;
        end

        if (vs_rise) begin
            vline_d   = 9'd0;
            seen_vs_d = 1'b1;
            ovf_d     = 1'b0;
            if (seen_vs_q && !ovf_q && (meas != 9'd511)) begin
                lpf_d        = meas;
                strobe_d     = 1'b1;
                locked_d     = (meas == prev_m_q) && prev_valid_q;
                prev_m_d     = meas;
                prev_valid_d = 1'b1;
            end else begin
                locked_d     = 1'b0;
                prev_valid_d = 1'b0;
            end
        end

        // Losing hsync overrides any measurement taken in the same cycle.
        if (timeout) begin
            hs_lost_d    = 1'b1;
            locked_d     = 1'b0;
            prev_valid_d = 1'b0;
            seen_vs_d    = 1'b0;
            strobe_d     = 1'b0;
            lpf_d        = lpf_q;
            prev_m_d     = prev_m_q;
        end
    end

    assign mode_50_d = locked_d && (lpf_d == LINES_50);
    assign mode_60_d = locked_d && (lpf_d == LINES_60);

    always_ff @(posedge clk) begin
        if (rst) begin
            hs_meta_q    <= 1'b0;
            hs_sync_q    <= 1'b0;
            hs_hist_q    <= 1'b0;
            vs_meta_q    <= 1'b0;
            vs_sync_q    <= 1'b0;
            vs_hist_q    <= 1'b0;
            vline_q      <= 9'd0;
            lpf_q        <= 9'd0;
            vs_width_q   <= 4'd0;
            width_cnt_q  <= 4'd0;
            strobe_q     <= 1'b0;
            locked_q     <= 1'b0;
            mode_50_q    <= 1'b0;
            mode_60_q    <= 1'b0;
            hs_lost_q    <= 1'b0;
            gap_q        <= 12'd0;
            prev_m_q     <= 9'd0;
            prev_valid_q <= 1'b0;
            seen_vs_q    <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            hs_meta_q    <= sync_if.hsync_in;
            hs_sync_q    <= hs_meta_q;
            hs_hist_q    <= hs_sync_q;
            vs_meta_q    <= sync_if.vsync_in;
            vs_sync_q    <= vs_meta_q;
            vs_hist_q    <= vs_sync_q;
            vline_q      <= vline_d;
            lpf_q        <= lpf_d;
            vs_width_q   <= vs_width_d;
            width_cnt_q  <= width_cnt_d;
            strobe_q     <= strobe_d;
            locked_q     <= locked_d;
            mode_50_q    <= mode_50_d;
            mode_60_q    <= mode_60_d;
            hs_lost_q    <= hs_lost_d;
            gap_q        <= gap_d;
            prev_m_q     <= prev_m_d;
            prev_valid_q <= prev_valid_d;
            seen_vs_q    <= seen_vs_d;
            ovf_q        <= ovf_d;
        end
    end

    assign sync_if.vline           = vline_q;
    assign sync_if.lines_per_frame = lpf_q;
    assign sync_if.vs_width        = vs_width_q;
    assign sync_if.frame_strobe    = strobe_q;
    assign sync_if.locked          = locked_q;
    assign sync_if.mode_50         = mode_50_q;
    assign sync_if.mode_60         = mode_60_q;
    assign sync_if.hs_lost         = hs_lost_q;

endmodule

// File: tb/tb_video_sync_meas.sv
// Drives randomized-period sync frames and checks every output against a frame-level model.
module tb_video_sync_meas;

    localparam logic [11:0] HTO = 12'd200;
    localparam int L50 = 320;
    localparam int L60 = 262;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    video_sync_meas_if vif();

    video_sync_meas #(
        .HTO      (HTO),
        .LINES_50 (9'd320),
        .LINES_60 (9'd262)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .sync_if (vif)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Frame-level reference state
    int hs_since_vs;
    int prev_m;
    int m_lpf;
    int m_vsw;
    bit seen;
    bit prev_valid;
    bit m_locked;
    bit m_lost;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        hs_since_vs = 0;
        prev_m      = 0;
        m_lpf       = 0;
        m_vsw       = 0;
        seen        = 1'b0;
        prev_valid  = 1'b0;
        m_locked    = 1'b0;
        m_lost      = 1'b0;
    endtask

    // A frame measurement counts only if a previous vsync was seen and fewer than 511 lines elapsed.
    task automatic model_vs_rise(input int c, output bit strobe);
        strobe = 1'b0;
        if (seen && c < 511) begin
            m_lpf      = c;
            m_locked   = prev_valid && (c == prev_m);
            prev_m     = c;
            prev_valid = 1'b1;
            strobe     = 1'b1;
        end else begin
            m_locked   = 1'b0;
            prev_valid = 1'b0;
        end
        seen = 1'b1;
    endtask

    task automatic check_outputs(input bit exp_strobe);
        check("frame_strobe", vif.frame_strobe, 16'(exp_strobe));
        check("vline", vif.vline, 16'((hs_since_vs > 511) ? 511 : hs_since_vs));
        check("lines_per_frame", vif.lines_per_frame, 16'(m_lpf));
        check("locked", vif.locked, 16'(m_locked));
        check("mode_50", vif.mode_50, 16'(m_locked && m_lpf == L50));
        check("mode_60", vif.mode_60, 16'(m_locked && m_lpf == L60));
        check("hs_lost", vif.hs_lost, 16'(m_lost));
        check("vs_width", vif.vs_width, 16'(m_vsw));
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(negedge clk);
        model_reset();
        check_outputs(1'b0);
        rst = 1'b0;
    endtask

    task automatic hsync_gap();
        repeat (int'(HTO) - 10) begin
            @(negedge clk);
            check("frame_strobe_gap", vif.frame_strobe, 16'd0);
        end
        check("hs_lost_before_hto", vif.hs_lost, 16'd0);
        repeat (20) @(negedge clk);
        m_lost     = 1'b1;
        m_locked   = 1'b0;
        prev_valid = 1'b0;
        seen       = 1'b0;
        check("hs_lost_after_hto", vif.hs_lost, 16'd1);
        check("locked_after_hto", vif.locked, 16'd0);
        check("mode_50_after_hto", vif.mode_50, 16'd0);
    endtask

    // n lines; vsync rises with line 0 and stays high for vsw lines (vsw < n).
    task automatic run_frame(input int n, input int vsw, input int rst_line, input int gap_line);
        for (int l = 0; l < n; l++) begin
            bit exp_st;
            int per;
            if (l == rst_line) pulse_reset();
            if (l == gap_line) hsync_gap();
            exp_st = 1'b0;
            if (l == 0) begin
                model_vs_rise(hs_since_vs + 1, exp_st);
                hs_since_vs = 0;
            end else begin
                hs_since_vs++;
            end
            if (l == vsw) m_vsw = (vsw > 15) ? 15 : vsw;
            m_lost = 1'b0;
            per = $urandom_range(5, 6);
            for (int k = 0; k < per; k++) begin
                if (k == 0) begin
                    vif.hsync_in = 1'b1;
                    if (l == 0) vif.vsync_in = 1'b1;
                end
                if (k == 2) begin
                    vif.hsync_in = 1'b0;
                    if (l == vsw - 1) vif.vsync_in = 1'b0;
                end
                @(negedge clk);
                if (k == 2) check_outputs(exp_st);
                else        check("frame_strobe_quiet", vif.frame_strobe, 16'd0);
            end
        end
    endtask

    initial begin
        int last_n;
        int n;
        rst          = 1'b1;
        vif.hsync_in = 1'b0;
        vif.vsync_in = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_outputs(1'b0);
        rst = 1'b0;

        // 50 Hz
        repeat (4) run_frame(L50, 4, -1, -1);
        check("lpf_50", vif.lines_per_frame, 16'd320);
        check("mode_50_set", vif.mode_50, 16'd1);
        check("vs_width_4", vif.vs_width, 16'd4);

        // 60 Hz
        repeat (4) run_frame(L60, 4, -1, -1);
        check("lpf_60", vif.lines_per_frame, 16'd262);
        check("mode_60_set", vif.mode_60, 16'd1);
        check("mode_50_clear", vif.mode_50, 16'd0);

        // Lock loss on a 319-line frame, then relock
        repeat (3) run_frame(L50, 4, -1, -1);
        repeat (3) run_frame(319, 4, -1, -1);
        check("lpf_319", vif.lines_per_frame, 16'd319);
        check("relock_319", vif.locked, 16'd1);

        // Hsync loss mid-frame
        run_frame(L50, 4, -1, 100);
        repeat (2) run_frame(L50, 4, -1, -1);

        // Vsync width saturation
        repeat (2) run_frame(L50, 18, -1, -1);
        check("vs_width_sat", vif.vs_width, 16'd15);

        // Missing vsync: vline saturates, next measurement discarded
        run_frame(600, 4, -1, -1);
        repeat (2) run_frame(L50, 4, -1, -1);

        // Reset mid-frame while locked
        run_frame(L50, 4, 150, -1);
        repeat (3) run_frame(L50, 4, -1, -1);

        // Random frame lengths and vsync widths
        last_n = 300;
        repeat (4) begin
            n = ($urandom_range(0, 1) != 0) ? last_n : int'($urandom_range(200, 330));
            run_frame(n, int'($urandom_range(1, 6)), -1, -1);
            last_n = n;
        end
        run_frame(20, 3, -1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
